// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the exec_pipe datapath
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } e_state_e;

    localparam int A0_IDX = 10;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file, x0 hardwired to zero, two read ports plus a0 tap
module reg_file
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] ra1,
    input  logic [ADDRESS_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0]    rd1,
    output logic [DATA_WIDTH-1:0]    rd2,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0]    wd,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // x0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
    assign a0  = regs[ADDRESS_WIDTH'(A0_IDX)];

endmodule

// File: rtl/exec_pipe.sv
// rtl/exec_pipe.sv - two-stage execute datapath with bypass and iterative multiply
module exec_pipe
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ALUctrl_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     ALUsrc,
    input  logic [ALUctrl_WIDTH-1:0] ALUctrl,
    input  logic                     RegWrite,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUout,
    output logic                     EQ,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int SHW = $clog2(DATA_WIDTH);

    e_state_e                 state;
    logic [SHW-1:0]           cnt;
    alu_op_e                  e_ctrl;
    logic [ADDRESS_WIDTH-1:0] e_rd;
    logic                     e_we;
    logic [DATA_WIDTH-1:0]    e_op1, e_op2;
    logic [DATA_WIDTH-1:0]    acc, mcand, mplier, mul_step;
    logic [DATA_WIDTH-1:0]    alu_res;
    logic [DATA_WIDTH-1:0]    rf_rd1, rf_rd2, op1, op2;
    logic                     complete, accept, wb_en;

    assign complete = (state == EXEC) || (state == MUL && cnt == SHW'(DATA_WIDTH - 1));
    assign in_ready = (state == IDLE) || complete;
    assign accept   = in_valid && in_ready;
    assign wb_en    = complete && e_we;

    reg_file #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (wb_en),
        .wa  (e_rd),
        .wd  (alu_res),
        .a0  (a0)
    );

    // A result being written back this edge is not yet in the file, so forward it
    always_comb begin
        op1 = rf_rd1;
        if (rs1 == '0)
            op1 = '0;
        else if (wb_en && e_rd == rs1)
            op1 = alu_res;

        op2 = rf_rd2;
        if (ALUsrc)
            op2 = ImmOp;
        else if (rs2 == '0)
            op2 = '0;
        else if (wb_en && e_rd == rs2)
            op2 = alu_res;
    end

    // Final partial product is folded in combinationally on the completion cycle
    assign mul_step = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = '0;
        case (e_ctrl)
            ALU_ADD: alu_res = e_op1 + e_op2;
            ALU_SUB: alu_res = e_op1 - e_op2;
            ALU_AND: alu_res = e_op1 & e_op2;
            ALU_OR:  alu_res = e_op1 | e_op2;
            ALU_XOR: alu_res = e_op1 ^ e_op2;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(e_op1) < $signed(e_op2)};
            ALU_SLL: alu_res = e_op1 << e_op2[SHW-1:0];
            ALU_MUL: alu_res = mul_step;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            e_ctrl    <= ALU_ADD;
            e_rd      <= '0;
            e_we      <= 1'b0;
            e_op1     <= '0;
            e_op2     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            out_valid <= 1'b0;
            ALUout    <= '0;
            EQ        <= 1'b0;
        end else begin
            out_valid <= complete;
            if (complete) begin
                ALUout <= alu_res;
                EQ     <= (e_op1 == e_op2);
            end

            if (accept) begin
                e_ctrl <= alu_op_e'(ALUctrl[2:0]);
                e_rd   <= rd;
                e_we   <= RegWrite;
                e_op1  <= op1;
                e_op2  <= op2;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= op1;
                mplier <= op2;
                state  <= (alu_op_e'(ALUctrl[2:0]) == ALU_MUL) ? MUL : EXEC;
            end else if (complete) begin
                state <= IDLE;
            end else if (state == MUL) begin
                cnt    <= cnt + 1'b1;
                acc    <= mul_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: tb/tb_exec_pipe.sv
// tb/tb_exec_pipe.sv - randomized self-checking bench for exec_pipe against an in-order ISA model
module tb_exec_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] ImmOp;
    logic          ALUsrc;
    logic [2:0]    ALUctrl;
    logic          RegWrite;
    logic          out_valid;
    logic [DW-1:0] ALUout;
    logic          EQ;
    logic [DW-1:0] a0;

    always #5 clk = ~clk;

    exec_pipe #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .ALUctrl_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .ImmOp     (ImmOp),
        .ALUsrc    (ALUsrc),
        .ALUctrl   (ALUctrl),
        .RegWrite  (RegWrite),
        .out_valid (out_valid),
        .ALUout    (ALUout),
        .EQ        (EQ),
        .a0        (a0)
    );

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        eq;
        int          rd;
        bit          we;
    } pend_t;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          ready_from;
    logic [31:0] arch [32];
    logic [31:0] vis  [32];
    logic [31:0] last_alu;
    pend_t       pq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << (b % 32);
            default: return p[31:0];
        endcase
    endfunction

    // Instructions complete in order, so architectural state is updated at accept
    task automatic model_accept();
        logic [31:0] a, b, r;
        pend_t p;
        a = (rs1 == 0) ? 32'd0 : arch[rs1];
        b = ALUsrc ? ImmOp : ((rs2 == 0) ? 32'd0 : arch[rs2]);
        r = ref_alu(ALUctrl, a, b);
        p.due = cyc + ((ALUctrl == 3'd7) ? DW + 1 : 2);
        p.res = r;
        p.eq  = (a == b);
        p.rd  = int'(rd);
        p.we  = RegWrite;
        if (RegWrite && rd != 0) arch[rd] = r;
        ready_from = cyc + ((ALUctrl == 3'd7) ? DW : 1);
        pq.push_back(p);
    endtask

    task automatic tick(output bit acc);
        bit exp_ready;
        @(negedge clk);
        exp_ready = (cyc >= ready_from);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        if (pq.size() > 0 && pq[0].due == cyc) begin
            check("out_valid", 64'(out_valid), 64'(1));
            check("aluout", 64'(ALUout), 64'(pq[0].res));
            check("eq", 64'(EQ), 64'(pq[0].eq));
            if (pq[0].we && pq[0].rd != 0) vis[pq[0].rd] = pq[0].res;
            last_alu = ALUout;
            pq.delete(0);
        end else begin
            check("out_valid_idle", 64'(out_valid), 64'(0));
        end
        check("a0", 64'(a0), 64'(vis[10]));
        acc = in_valid && exp_ready;
        if (acc) model_accept();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic [31:0] imm, input bit src, input logic [2:0] op, input bit we);
        bit acc;
        int guard;
        rs1 = r1; rs2 = r2; rd = d; ImmOp = imm; ALUsrc = src; ALUctrl = op; RegWrite = we;
        in_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < DW + 8) begin
            tick(acc);
            guard++;
        end
        if (!acc) check("accept_timeout", 64'(guard), 64'(0));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        int g;
        in_valid = 1'b0;
        g = 0;
        while (pq.size() > 0 && g < 200) begin
            tick(acc);
            g++;
        end
        if (pq.size() > 0) check("drain_timeout", 64'(pq.size()), 64'(0));
    endtask

    // Abandons anything in flight; hold_valid leaves an offered instruction up across the reset edge
    task automatic do_reset(input bit hold_valid);
        rst = 1'b1;
        if (!hold_valid) in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        cyc = 0;
        ready_from = 0;
        pq.delete();
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            vis[i]  = '0;
        end
        #1;
        check("rst_aluout", 64'(ALUout), 64'(0));
        check("rst_eq", 64'(EQ), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; ready_from = 0; last_alu = '0;
        rst = 1'b1; in_valid = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; ImmOp = '0; ALUsrc = 1'b0; ALUctrl = '0; RegWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);

        issue(0, 0, 1, 32'd5, 1, 3'd0, 1);
        issue(1, 0, 2, 32'd0, 1, 3'd0, 1);
        issue(0, 0, 10, 32'd7, 1, 3'd0, 1);
        issue(10, 10, 10, 32'd0, 0, 3'd1, 1);
        drain();

        issue(0, 0, 3, 32'hFFFF_FFFF, 1, 3'd0, 1);
        issue(3, 0, 4, 32'd3, 1, 3'd7, 1);
        issue(4, 0, 5, 32'd0, 1, 3'd0, 1);
        drain();
        check("mul_low_bits", 64'(last_alu), 64'(32'hFFFF_FFFD));

        issue(0, 0, 7, 32'hFFFF_FFFF, 1, 3'd0, 1);
        issue(0, 0, 8, 32'd1, 1, 3'd0, 1);
        issue(7, 8, 9, 32'd0, 0, 3'd5, 1);
        issue(0, 0, 5, 32'd1, 1, 3'd0, 1);
        issue(5, 0, 6, 32'd35, 1, 3'd6, 1);
        issue(0, 0, 0, 32'd9, 1, 3'd0, 1);
        issue(0, 0, 11, 32'd0, 0, 3'd3, 1);
        drain();

        issue(0, 0, 12, 32'h55, 1, 3'd0, 1);
        rs1 = 0; rd = 14; ImmOp = 32'h77; ALUsrc = 1; ALUctrl = 3'd0; RegWrite = 1;
        in_valid = 1'b1;
        do_reset(1);
        idle(3);

        issue(0, 0, 13, 32'd6, 1, 3'd0, 1);
        issue(13, 0, 13, 32'd5, 1, 3'd7, 1);
        idle(10);
        do_reset(0);
        idle(3);

        for (int n = 0; n < 1000; n++) begin
            logic [2:0]  op;
            logic [31:0] imm;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            op  = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  imm, 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 7) != 0));
        end
        drain();
        idle(2);

        for (int i = 0; i < 32; i++)
            check($sformatf("regfile_x%0d", i), 64'(dut.u_rf.regs[i]), 64'(vis[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_pipe.md
# exec_pipe

Parametrised two-stage execute datapath: a register file (x0 hardwired to zero) feeding an ALU, with a valid/ready instruction handshake. Registered result, same-edge writeback with operand bypass, and an iterative multi-cycle multiply that stalls the input. It sits between the decode/control logic and the architectural register state, and exposes a0 (x10) for observation.

## Interface
- DATA_WIDTH, 32, operand/register width (≥ 8)
- ADDRESS_WIDTH, 5, register index width; file depth 2**ADDRESS_WIDTH (≥ 4, so x10 exists when ADDRESS_WIDTH ≥ 4)
- ALUctrl_WIDTH, 3, ALU opcode width (fixed at 3 by encoding)

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept this cycle
- rs1, rs2, rd  in  ADDRESS_WIDTH  source/destination indices
- ImmOp  in  DATA_WIDTH  immediate operand
- ALUsrc  in  1  1: op2 = ImmOp, 0: op2 = reg[rs2]
- ALUctrl  in  3  operation
- RegWrite  in  1  write result to rd
- out_valid  out  1  one-cycle pulse: ALUout/EQ valid
- ALUout  out  DATA_WIDTH  registered result
- EQ  out  1  registered (op1 == op2)
- a0  out  DATA_WIDTH  current contents of x10

## Operation
- Accept on edge where in_valid && in_ready. Operands and controls are captured into stage E.
- Operand read priority: rs==0 → 0; else E completing this edge with RegWrite && rd==rs && rd!=0 → E result (bypass); else reg file.
- ALUctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1), 110 SLL (shift = op2[$clog2(DATA_WIDTH)-1:0]), 111 MUL (low DATA_WIDTH bits of product).
- ADD/SUB/MUL wrap modulo 2**DATA_WIDTH; no flags besides EQ.
- E FSM states:
  - IDLE: E empty.
  - EXEC: single-cycle op; completes on the next edge.
  - MUL: shift-add; counter 0..DATA_WIDTH-1; completes on the edge where counter == DATA_WIDTH-1.
- Transitions from completion: back-to-back accept goes to EXEC/MUL, otherwise IDLE.
- in_ready = (state==IDLE) || E completing this edge.
- On completion edge:
  - ALUout/EQ are registered and out_valid is set for one cycle.
  - If RegWrite && rd!=0, reg[rd] is written on the same edge.
- Writes to x0 are dropped; x0 always reads 0.
- a0 = reg[10] combinationally; it reflects a write from the cycle after the write edge.
- No output backpressure; out_valid is a pulse and the consumer must sample it.

## Timing
- Reset values:
  - out_valid=0, ALUout=0, EQ=0.
  - All registers 0, so a0=0.
  - state=IDLE, counter=0, in_ready=1 in the cycle after reset.
- Single-cycle op accepted at edge k → out_valid high in cycle k+2 (latency 2). Throughput 1/cycle.
- MUL accepted at edge k → out_valid in cycle k+DATA_WIDTH+1. in_ready stays low for DATA_WIDTH-1 cycles, then goes high in the completion cycle.
- Dependent back-to-back instruction (rs == previous rd) receives the bypassed value with no bubble.
- rst asserted mid-MUL or mid-EXEC: the instruction is abandoned, with no writeback and no out_valid. rst overrides a simultaneous accept.
- in_valid while in_ready=0: ignored. The source must hold the instruction.

## Structure
- Package exec_pkg holds:
  - alu_op_e enum (the 8 encodings above)
  - e_state_e enum {IDLE, EXEC, MUL}
  - localparam A0_IDX = 10
- Sub-module reg_file:
  - 2 combinational read ports, 1 synchronous write port.
  - Synchronous reset clears all entries; x0 write suppressed.
  - Extra a0 read port.
- ALU combinational logic and the MUL iterator live in exec_pipe.

## Test plan
- Reset, then ADD x1 = x0 + Imm 5 (ALUsrc=1, rd=1): out_valid in cycle 2 after accept, ALUout=5, EQ=0; next instruction reads x1=5.
- ADDI x10=7 immediately followed by SUB x10 = x10 - x10 (rs1=rs2=10, ALUsrc=0): bypass gives ALUout=0 and EQ=1; a0 shows 7 then 0.
- Accept MUL with rs1 holding 0xFFFF_FFFF and Imm 3: in_ready low for 31 cycles; ALUout=0xFFFF_FFFD after 33 cycles; a second instruction offered during the stall is accepted only at completion.
- SLT with -1 vs 1 → 1; SLL 1 by Imm 35 (amount 3) → 8; write to x0 with Imm 9 → x0 still reads 0.
- Assert rst during MUL counter = 10: no out_valid, rd unchanged (0), in_ready=1 the cycle after reset.
- Random stream of 1000 instructions vs. a reference model: every out_valid value and the final register file match.
